// File: rtl/rvga_mem_req_pkg.sv
// Shared types for the core-side memory initiator: access sizes, FSM states
// and the captured request record.
package rvga_mem_req_pkg;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } rvga_mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } rvga_mem_req_state_e;

    typedef struct packed {
        logic           we;
        rvga_mem_size_e size;
        logic           is_unsigned;
        rvga_word       addr;
        rvga_word       wdata;
    } rvga_mem_req_t;

    // Illegal size code, or an access that straddles its natural alignment.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'b11) ||
               (size == 2'b01 && lo[0]) ||
               (size == 2'b10 && lo != 2'b00);
    endfunction

endpackage

// File: rtl/rvga_mem_lane.sv
// Byte-lane steering for one memory word: extracts and extends a load value,
// and merges right-justified store data into the word at the selected lane.
module rvga_mem_lane
    import rvga_mem_req_pkg::*;
(
    input  rvga_word       word_i,
    input  logic [1:0]     lane_i,
    input  rvga_mem_size_e size_i,
    input  logic           unsigned_i,
    input  rvga_word       wdata_i,
    output rvga_word       load_o,
    output rvga_word       merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word_i[{lane_i, 3'b000} +: 8];
        half_v  = lane_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            MEM_BYTE: begin
                load_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            MEM_HALF: begin
                load_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
                else           merge_o[15:0]  = wdata_i[15:0];
            end
            MEM_WORD: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/rvga_mem_req.sv
// Core-side memory initiator: one load/store at a time onto a word-wide
// responder, with sub-word read-modify-write, alignment checks and a timeout.
module rvga_mem_req
    import rvga_mem_req_pkg::*;
#(
    parameter int unsigned timeout_p = 16,
    parameter int unsigned debug_p   = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_v_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  rvga_word            req_addr_i,
    input  rvga_word            req_wdata_i,
    output logic                resp_v_o,
    output logic                resp_err_o,
    output rvga_word            resp_rdata_o,
    output logic                mem_r_v_o,
    output logic                mem_w_v_o,
    output rvga_word            mem_addr_o,
    output rvga_word            mem_wdata_o,
    input  rvga_word            mem_rdata_i,
    input  logic                mem_resp_v_i,
    output rvga_mem_req_state_e dbg_state_o,
    output logic                dbg_trace_o
);

    localparam int CW = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(timeout_p - 1);

    rvga_mem_req_state_e state_q;
    rvga_mem_req_t       req_q;
    logic [CW-1:0]       cnt_q;
    rvga_word            lane_load;
    rvga_word            lane_merge;

    // Handshake: a request transfers on the rising edge where req_v_i and
    // req_ready_o are both high; ready is high exactly while the FSM idles,
    // and the response is a single resp_v_o pulse with no back-pressure.
    wire accept = req_v_i && req_ready_o;

    rvga_mem_lane u_lane (
        .word_i     (mem_rdata_i),
        .lane_i     (req_q.addr[1:0]),
        .size_i     (req_q.size),
        .unsigned_i (req_q.is_unsigned),
        .wdata_i    (req_q.wdata),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    assign mem_addr_o  = (mem_r_v_o || mem_w_v_o) ? {req_q.addr[31:2], 2'b00} : '0;
    assign dbg_state_o = state_q;
    assign dbg_trace_o = (debug_p != 0) && (accept || resp_v_o);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            req_ready_o  <= 1'b1;
            resp_v_o     <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            mem_r_v_o    <= 1'b0;
            mem_w_v_o    <= 1'b0;
            mem_wdata_o  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        req_q       <= '{we: req_we_i, size: rvga_mem_size_e'(req_size_i),
                                         is_unsigned: req_unsigned_i, addr: req_addr_i,
                                         wdata: req_wdata_i};
                        cnt_q       <= '0;
                        req_ready_o <= 1'b0;
                        if (req_bad(req_size_i, req_addr_i[1:0])) begin
                            state_q    <= ST_RESP;
                            resp_v_o   <= 1'b1;
                            resp_err_o <= 1'b1;
                        end else if (req_we_i && req_size_i == MEM_WORD) begin
                            state_q     <= ST_WR;
                            mem_w_v_o   <= 1'b1;
                            mem_wdata_o <= req_wdata_i;
                        end else begin
                            state_q   <= ST_RD;
                            mem_r_v_o <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (mem_resp_v_i) begin
                        mem_r_v_o <= 1'b0;
                        cnt_q     <= '0;
                        if (req_q.we) begin
                            state_q     <= ST_WR;
                            mem_w_v_o   <= 1'b1;
                            mem_wdata_o <= lane_merge;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_v_o     <= 1'b1;
                            resp_rdata_o <= lane_load;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        mem_r_v_o  <= 1'b0;
                        state_q    <= ST_RESP;
                        resp_v_o   <= 1'b1;
                        resp_err_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WR: begin
                    if (mem_resp_v_i || cnt_q == CNT_LAST) begin
                        mem_w_v_o   <= 1'b0;
                        mem_wdata_o <= '0;
                        state_q     <= ST_RESP;
                        resp_v_o    <= 1'b1;
                        resp_err_o  <= !mem_resp_v_i;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    // RESP lasts one cycle; a late ack arriving here is ignored.
                    state_q      <= ST_IDLE;
                    req_ready_o  <= 1'b1;
                    resp_v_o     <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rvga_mem_req.md
Name: rvga_mem_req

Overview:
- Core-side memory initiator that drives the word-wide, byte-addressed memory responder interface (r_v / w_v / addr / data / resp_v).
- Accepts one load/store request at a time from the pipeline and handles byte/half/word sizing, sign extension, and read-modify-write for sub-word stores.
- Checks alignment and guards against a hung responder with a timeout.
- Sits between the core's memory stage and the DDR/test memory.

Parameters:
- timeout_p, 16, max cycles to wait for mem_resp_v_i in any memory state before aborting with error; must be ≥1.
- debug_p, 0, when 1, $display each accepted request and each response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- req_v_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal
- req_unsigned_i  in  1  zero-extend sub-word loads
- req_addr_i  in  32  byte address (rvga_word)
- req_wdata_i  in  32  store data, right-justified
- resp_v_o  out  1  one-cycle response pulse
- resp_err_o  out  1  misaligned, illegal size, or timeout; valid with resp_v_o
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- mem_r_v_o  out  1  read strobe
- mem_w_v_o  out  1  write strobe
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata_o  out  32  full merged write word
- mem_rdata_i  in  32  read data, valid when mem_resp_v_i is high
- mem_resp_v_i  in  1  responder ack; may arrive in the same cycle as the strobe

Behaviour:
- Reset: while rst_i is low, FSM = IDLE and all outputs are 0 except req_ready_o = 1. Takes effect immediately (asynchronous), including mid-operation; the in-flight request is dropped and no response is issued.
- States: IDLE, RD, WR, RESP.
- req_ready_o = (state == IDLE). A request is captured on the clock edge where req_v_i & req_ready_o. The captured copy is used for the whole transaction, so inputs may change afterwards.
- Error check at capture:
  - size 11 → err
  - half with addr[0] = 1 → err
  - word with addr[1:0] ≠ 0 → err
  - On err: IDLE → RESP, no memory strobe.
- Routing from IDLE:
  - load → RD
  - word store → WR
  - byte/half store → RD (read-modify-write)
- RD:
  - mem_r_v_o = 1, mem_addr_o = aligned address.
  - On mem_resp_v_i, capture mem_rdata_i, then go to RESP (load) or WR (store).
- WR:
  - mem_w_v_o = 1.
  - mem_wdata_o = word store: req_wdata; sub-word store: captured read word with the lane replaced.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - On mem_resp_v_i → RESP.
- RESP:
  - resp_v_o = 1 for exactly one cycle, then → IDLE. The next request can be accepted in the cycle after RESP.
- Load extraction: select byte/half by lane; sign-extend unless req_unsigned_i. Word loads ignore req_unsigned_i.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle without mem_resp_v_i.
  - When it reaches timeout_p, go to RESP with resp_err_o = 1 and drop the strobe. A stale ack after abort is ignored.
- Latency with a same-cycle responder (accept edge = cycle 0):
  - load: resp_v_o at cycle 2
  - word store: resp_v_o at cycle 2
  - sub-word store: resp_v_o at cycle 3
  - error: resp_v_o at cycle 1
- mem_r_v_o and mem_w_v_o are never high together.

Decomposition:
- Add to rvga_types:
  - rvga_mem_size enum (BYTE, HALF, WORD)
  - rvga_mem_req_state enum (IDLE, RD, WR, RESP)
  - rvga_mem_req struct {we, size, unsigned, addr, wdata} for the captured request.
- One sub-module, rvga_mem_lane: combinational load-extract plus store-merge (inputs: word, lane, size, unsigned, wdata). Shared with future cache logic.

Test Plan:
All scenarios use the identity-initialised memory model (word at addr i holds i), with a same-cycle ack.
- LW 0x10 → mem_r_v_o at cycle 1, addr 0x10; resp_v_o at cycle 2 with rdata 0x00000010, err 0; no mem_w_v_o.
- SB 0x21 data 0xAB → RD 0x20, then WR 0x20 with wdata 0x0000AB20, resp at cycle 3. A following LW 0x20 returns 0x0000AB20.
- After the store above:
  - LB 0x21 → 0xFFFFFFAB
  - LBU 0x21 → 0x000000AB
  - LH 0x20 → 0xFFFFAB20
- LH 0x13, LW 0x22, and size 11 → resp_err_o = 1 at cycle 1; rdata 0; mem strobes stay 0 throughout.
- mem_resp_v_i tied 0, timeout_p = 8, LW 0x04 → mem_r_v_o high for 8 cycles, then resp_v_o with err 1; ready again the next cycle.
- rst_i driven low mid-WR (between clock edges) → mem_w_v_o and resp_v_o drop immediately, req_ready_o = 1; after release, a new LW 0x08 completes normally with 0x00000008.
